// File: rtl/adc_spi_responder_pkg.sv
// ---------------------------------------------------------------------------------------------
// adc_spi_responder_pkg
//   Shared constants for the dual-channel ADC SPI frame: default field widths, frame length,
//   FSM state encodings, and a helper that maps a falling-edge count to the frame slot.
// ---------------------------------------------------------------------------------------------
package adc_spi_responder_pkg;

    localparam int unsigned DATA_W_DEF      = 14;
    localparam int unsigned LEAD_BITS_DEF   = 2;
    localparam int unsigned GAP_BITS_DEF    = 2;
    localparam int unsigned TAIL_BITS_DEF   = 2;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Frame slot encodings (legacy-compatible constants shared with the ADC2 master)
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLead = 3'd1;
    localparam logic [2:0] StCh0  = 3'd2;
    localparam logic [2:0] StGap  = 3'd3;
    localparam logic [2:0] StCh1  = 3'd4;
    localparam logic [2:0] StTail = 3'd5;

    // Total sck cycles in one frame: lead + ch0 + gap + ch1 + tail
    function automatic int unsigned frame_sck(input int unsigned lead, input int unsigned w,
                                              input int unsigned gap, input int unsigned tail);
        return lead + w + gap + w + tail;
    endfunction

    localparam int unsigned FRAME_SCK = LEAD_BITS_DEF + 2 * DATA_W_DEF + GAP_BITS_DEF
                                        + TAIL_BITS_DEF;

    // Slot the frame is in after n falling edges since frame start
    function automatic logic [2:0] slot_state(input int unsigned n, input int unsigned lead,
                                              input int unsigned w, input int unsigned gap,
                                              input int unsigned tail);
        if (n < lead)                                  return StLead;
        else if (n < lead + w)                         return StCh0;
        else if (n < lead + w + gap)                   return StGap;
        else if (n < lead + 2 * w + gap)               return StCh1;
        else if (n < frame_sck(lead, w, gap, tail))    return StTail;
        else                                           return StIdle;
    endfunction

endpackage

// File: rtl/adc_spi_responder_spi_edge_sync.sv
// ---------------------------------------------------------------------------------------------
// spi_edge_sync
//   Multi-flop synchronizer followed by a history flop; emits single-cycle rise/fall pulses
//   for an asynchronous input pin.
// Ports
//   clk     in   system clock
//   rst     in   asynchronous reset, active-high
//   din_i   in   asynchronous pin
//   rise_o  out  1-cycle pulse, synced rising edge detected
//   fall_o  out  1-cycle pulse, synced falling edge detected
// ---------------------------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------------------------
// adc_spi_responder
//   SPI responder for the dual-channel ADC frame. A synced adc_conv rise snapshots the holding
//   registers; the two samples are then shifted out MSB-first, advancing on synced spi_sck
//   falling edges through LEAD / CH0 / GAP / CH1 / TAIL slots.
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   ch0_sample, ch1_sample   sample values copied into holding regs on sample_load
//   sample_load              1-cycle load strobe
//   adc_conv                 frame start (rising edge)
//   spi_sck                  serial clock from master
//   spi_miso, miso_oe        serial data and its drive-enable (data slots only)
//   busy                     frame in progress
//   frame_done, frame_abort  1-cycle status pulses
// ---------------------------------------------------------------------------------------------
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned LEAD_BITS   = LEAD_BITS_DEF,
    parameter int unsigned GAP_BITS    = GAP_BITS_DEF,
    parameter int unsigned TAIL_BITS   = TAIL_BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ch0_sample,
    input  logic [DATA_W-1:0] ch1_sample,
    input  logic              sample_load,
    input  logic              adc_conv,
    input  logic              spi_sck,
    output logic              spi_miso,
    output logic              miso_oe,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam logic [5:0] FRAME_CNT = 6'(frame_sck(LEAD_BITS, DATA_W, GAP_BITS, TAIL_BITS));

    logic              sck_fall, sck_rise_unused;
    logic              conv_rise, conv_fall_unused;

    logic [2:0]        state_q, state_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic [DATA_W-1:0] shift0_q, shift0_d, shift1_q, shift1_d;
    logic              done_q, done_d, abort_q, abort_d;
    logic [5:0]        cnt_inc;
    logic              frame_end;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (spi_sck),
        .rise_o (sck_rise_unused),
        .fall_o (sck_fall)
    );

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_conv_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (adc_conv),
        .rise_o (conv_rise),
        .fall_o (conv_fall_unused)
    );

    assign cnt_inc   = bit_cnt_q + 6'd1;
    assign frame_end = (state_q != StIdle) && sck_fall && (cnt_inc == FRAME_CNT);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        hold0_d   = hold0_q;
        hold1_d   = hold1_q;
        shift0_d  = shift0_q;
        shift1_d  = shift1_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        if (sample_load) begin
            hold0_d = ch0_sample;
            hold1_d = ch1_sample;
        end

        if (conv_rise) begin
            // A conv rise coinciding with the last edge completes that frame first, so it
            // reports done rather than abort.
            if (frame_end) begin
                done_d = 1'b1;
            end else if (state_q != StIdle) begin
                abort_d = 1'b1;
            end
            // Snapshot uses the registered holding values, i.e. the pre-load ones on collision.
            shift0_d  = hold0_q;
            shift1_d  = hold1_q;
            bit_cnt_d = '0;
            state_d   = StLead;
        end else if ((state_q != StIdle) && sck_fall) begin
            // The MSB is presented on entry to a data slot; each later edge in the slot
            // exposes the next bit.
            if (state_q == StCh0) shift0_d = shift0_q << 1;
            if (state_q == StCh1) shift1_d = shift1_q << 1;
            if (frame_end) begin
                state_d   = StIdle;
                bit_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = cnt_inc;
                state_d   = slot_state(32'(cnt_inc), LEAD_BITS, DATA_W, GAP_BITS, TAIL_BITS);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            hold0_q   <= '0;
            hold1_q   <= '0;
            shift0_q  <= '0;
            shift1_q  <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
            shift0_q  <= shift0_d;
            shift1_q  <= shift1_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        spi_miso = 1'b0;
        miso_oe  = 1'b0;
        if (state_q == StCh0) begin
            spi_miso = shift0_q[DATA_W-1];
            miso_oe  = 1'b1;
        end else if (state_q == StCh1) begin
            spi_miso = shift1_q[DATA_W-1];
            miso_oe  = 1'b1;
        end
    end

    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule
